// File: rtl/mvm_pkg.sv
// Shared widths, element/product/sum types and framing states for the MVM datapath.
package mvm_pkg;

   localparam int LANES     = 8;
   localparam int IWIDTH    = 8;
   localparam int OWIDTH    = 32;
   localparam int TREE_LVLS = $clog2(LANES);

   typedef logic signed [IWIDTH-1:0]   elem_t;
   typedef logic signed [2*IWIDTH-1:0] prod_t;
   typedef logic signed [OWIDTH-1:0]   sum_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OPEN = 1'b1
   } frame_state_t;

endpackage

// File: rtl/add_tree.sv
// Registered binary adder tree, one register level per tree level, with
// valid/first/last sideband delayed to the same depth.
module add_tree #(
   parameter int N  = 8,
   parameter int OW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vld_in,
   input  logic                 fst_in,
   input  logic                 lst_in,
   input  logic signed [OW-1:0] din [N],
   output logic signed [OW-1:0] dout,
   output logic                 vld_out,
   output logic                 fst_out,
   output logic                 lst_out
);

   localparam int LV = $clog2(N);

   logic [LV-1:0] vld_q, fst_q, lst_q;
   logic [LV-1:0] en;

   // en[s] is the valid entering tree stage s+1
   assign en = LV'({vld_q, vld_in});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         fst_q <= '0;
         lst_q <= '0;
      end else begin
         vld_q <= en;
         fst_q <= LV'({fst_q, fst_in});
         lst_q <= LV'({lst_q, lst_in});
      end
   end

   // Heap-ordered nodes: node[1] is the root, children of k are 2k and 2k+1;
   // indices >= N refer to the leaf inputs din[idx-N].
   logic signed [OW-1:0] node [1:N-1];

   for (genvar k = 1; k < N; k++) begin : g_node
      localparam int D = $clog2(k + 1) - 1;
      localparam int S = LV - D;
      logic signed [OW-1:0] a, b;

      if (2 * k >= N) begin : g_leaf
         assign a = din[2*k-N];
         assign b = din[2*k+1-N];
      end else begin : g_inner
         assign a = node[2*k];
         assign b = node[2*k+1];
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst)
            node[k] <= '0;
         else if (en[S-1])
            node[k] <= a + b;
      end
   end

   assign dout    = node[1];
   assign vld_out = vld_q[LV-1];
   assign fst_out = fst_q[LV-1];
   assign lst_out = lst_q[LV-1];

endmodule

// File: rtl/dot_pipe.sv
// LANES-wide signed dot-product stage: input regs, product regs, then a
// registered adder tree; also watches first/last framing and flags misuse.
//
//   state | meaning
//   IDLE  | between groups, next valid beat must carry first
//   OPEN  | inside a group, waiting for the beat carrying last
import mvm_pkg::*;

module dot_pipe #(
   parameter int LANES  = mvm_pkg::LANES,
   parameter int IWIDTH = mvm_pkg::IWIDTH,
   parameter int OWIDTH = mvm_pkg::OWIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ivalid,
   input  logic                      first,
   input  logic                      last,
   input  logic [LANES*IWIDTH-1:0]   vec,
   input  logic [LANES*IWIDTH-1:0]   mat,
   output logic signed [OWIDTH-1:0]  result,
   output logic                      ovalid,
   output logic                      ofirst,
   output logic                      olast,
   output logic                      err
);

   localparam int PW = 2 * IWIDTH;

   logic                    v1, f1, l1;
   logic [LANES*IWIDTH-1:0] vec_r, mat_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1    <= 1'b0;
         f1    <= 1'b0;
         l1    <= 1'b0;
         vec_r <= '0;
         mat_r <= '0;
      end else begin
         v1 <= ivalid;
         f1 <= first & ivalid;
         l1 <= last & ivalid;
         if (ivalid) begin
            vec_r <= vec;
            mat_r <= mat;
         end
      end
   end

   logic signed [IWIDTH-1:0] va [LANES];
   logic signed [IWIDTH-1:0] ma [LANES];

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         va[i] = vec_r[i*IWIDTH +: IWIDTH];
         ma[i] = mat_r[i*IWIDTH +: IWIDTH];
      end
   end

   logic                 v2, f2, l2;
   logic signed [PW-1:0] prod_r [LANES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v2 <= 1'b0;
         f2 <= 1'b0;
         l2 <= 1'b0;
         for (int i = 0; i < LANES; i++)
            prod_r[i] <= '0;
      end else begin
         v2 <= v1;
         f2 <= f1;
         l2 <= l1;
         if (v1) begin
            for (int i = 0; i < LANES; i++)
               prod_r[i] <= PW'(va[i]) * PW'(ma[i]);
         end
      end
   end

   logic signed [OWIDTH-1:0] ext [LANES];

   always_comb begin
      for (int i = 0; i < LANES; i++)
         ext[i] = OWIDTH'(prod_r[i]);
   end

   add_tree #(
      .N  (LANES),
      .OW (OWIDTH)
   ) u_tree (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (v2),
      .fst_in  (f2),
      .lst_in  (l2),
      .din     (ext),
      .dout    (result),
      .vld_out (ovalid),
      .fst_out (ofirst),
      .lst_out (olast)
   );

   frame_state_t state, state_nx;
   logic         err_set;

   // A stray first while OPEN restarts the group, so it is handled like a first from IDLE.
   always_comb begin
      state_nx = state;
      err_set  = 1'b0;
      if (ivalid) begin
         if (first) begin
            err_set  = (state == OPEN);
            state_nx = last ? IDLE : OPEN;
         end else if (state == IDLE) begin
            err_set  = 1'b1;
         end else begin
            state_nx = last ? IDLE : OPEN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         if (err_set)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dot_pipe.sv
// Bench for dot_pipe: directed framing/extreme cases plus random beats
// compared against a cycle-stamped queue of arithmetic dot products.
module tb_dot_pipe;

   localparam int LANES = 8;
   localparam int LAT   = 5;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               ivalid = 1'b0;
   logic               first = 1'b0;
   logic               last = 1'b0;
   logic [63:0]        vec = '0;
   logic [63:0]        mat = '0;
   logic signed [31:0] result;
   logic               ovalid, ofirst, olast, err;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int due;
      int res;
      bit f;
      bit l;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   bit   m_open = 0;
   bit   m_err = 0;
   int   n_out = 0;
   int   n_of = 0;
   int   n_ol = 0;
   logic signed [31:0] last_res = '0;

   always #5 clk = ~clk;

   dot_pipe u_dut (
      .clk    (clk),
      .rst    (rst),
      .ivalid (ivalid),
      .first  (first),
      .last   (last),
      .vec    (vec),
      .mat    (mat),
      .result (result),
      .ovalid (ovalid),
      .ofirst (ofirst),
      .olast  (olast),
      .err    (err)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int dot(input logic [63:0] v, input logic [63:0] m);
      int s;
      int a;
      int b;
      s = 0;
      for (int i = 0; i < LANES; i++) begin
         a = $signed(v[i*8 +: 8]);
         b = $signed(m[i*8 +: 8]);
         s = s + a * b;
      end
      return s;
   endfunction

   // Reference model: each accepted beat becomes an expected output LAT cycles later.
   always @(posedge clk or negedge rst) begin
      exp_t e;
      if (!rst) begin
         q.delete();
         m_open = 0;
         m_err  = 0;
      end else begin
         if (ivalid) begin
            e.due = cyc + LAT;
            e.res = dot(vec, mat);
            e.f   = first;
            e.l   = last;
            q.push_back(e);
            if (first) begin
               if (m_open) m_err = 1;
               m_open = !last;
            end else if (!m_open) begin
               m_err = 1;
            end else begin
               m_open = !last;
            end
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      bit ev;
      if (!rst) begin
         chk("rst_ovalid", ovalid, 0);
         chk("rst_ofirst", ofirst, 0);
         chk("rst_olast", olast, 0);
         chk("rst_result", result, 0);
         chk("rst_err", err, 0);
      end else begin
         ev = (q.size() > 0) && (q[0].due == cyc);
         chk("ovalid", ovalid, ev);
         if (ev) begin
            chk("result", result, q[0].res);
            chk("ofirst", ofirst, q[0].f);
            chk("olast", olast, q[0].l);
            void'(q.pop_front());
         end else begin
            chk("ofirst_idle", ofirst, 0);
            chk("olast_idle", olast, 0);
         end
         chk("err", err, m_err);
         if (ovalid === 1'b1) begin
            n_out++;
            last_res = result;
            if (ofirst === 1'b1) n_of++;
            if (olast === 1'b1) n_ol++;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         ivalid = 0;
         first  = 0;
         last   = 0;
      end
   endtask

   task automatic beat(input bit f, input bit l, input logic [63:0] v, input logic [63:0] m);
      @(posedge clk);
      #1;
      ivalid = 1;
      first  = f;
      last   = l;
      vec    = v;
      mat    = m;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst    = 0;
      ivalid = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      int o0, f0, l0;
      bit rf, rl;

      #1;
      chk("init_ovalid", ovalid, 0);
      chk("init_err", err, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1;
      idle(2);

      // single beat
      o0 = n_out; f0 = n_of; l0 = n_ol;
      beat(1, 1, {8{8'd2}}, {8{8'd3}});
      idle(LAT + 2);
      chk("t1_res", last_res, 48);
      chk("t1_cnt", n_out - o0, 1);
      chk("t1_ofirst", n_of - f0, 1);
      chk("t1_olast", n_ol - l0, 1);
      chk("t1_err", err, 0);

      // signed extremes
      beat(1, 1, {8{8'h80}}, {8{8'h80}});
      idle(LAT + 2);
      chk("t2_maxpos", last_res, 131072);
      beat(1, 1, {8{8'h80}}, {8{8'h7f}});
      idle(LAT + 2);
      chk("t2_maxneg", last_res, -130048);

      // four-beat group with a gap
      o0 = n_out; f0 = n_of; l0 = n_ol;
      beat(1, 0, rnd64(), rnd64());
      beat(0, 0, rnd64(), rnd64());
      idle(1);
      beat(0, 0, rnd64(), rnd64());
      beat(0, 1, rnd64(), rnd64());
      idle(LAT + 2);
      chk("t3_cnt", n_out - o0, 4);
      chk("t3_ofirst", n_of - f0, 1);
      chk("t3_olast", n_ol - l0, 1);
      chk("t3_err", err, 0);

      // framing errors
      do_reset();
      beat(0, 0, rnd64(), rnd64());
      idle(1);
      chk("t4_nofirst", err, 1);
      idle(4);
      chk("t4_sticky", err, 1);
      do_reset();
      beat(1, 0, rnd64(), rnd64());
      beat(1, 0, rnd64(), rnd64());
      idle(1);
      chk("t4_dblfirst", err, 1);
      idle(LAT);

      // async reset with beats in flight
      beat(1, 0, rnd64(), rnd64());
      beat(0, 0, rnd64(), rnd64());
      beat(0, 1, rnd64(), rnd64());
      @(posedge clk);
      #2;
      rst    = 0;
      ivalid = 0;
      #1;
      chk("t5_ovalid", ovalid, 0);
      chk("t5_result", result, 0);
      chk("t5_err", err, 0);
      @(posedge clk);
      #1;
      rst = 1;
      o0 = n_out;
      idle(10);
      chk("t5_no_ovalid", n_out - o0, 0);

      // random traffic
      o0 = n_out;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         rf = ($urandom_range(0, 3) == 0);
         rl = ($urandom_range(0, 3) == 0);
         beat(rf, rl, rnd64(), rnd64());
      end
      idle(LAT + 3);
      chk("t6_count", n_out - o0, 1000);
      chk("t6_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
